updown_counter: RTL and testbench
=================================

Name: updown_counter

Overview:
Parametrised successor to the basic clear/increment counter. Adds:
- up/down counting
- synchronous load
- wrap or saturate mode
- a registered terminal-count pulse and a sticky overflow flag

Used as a generic event/timeout counter in datapath and control blocks. Single clock domain.

Parameters:
WIDTH, 8, counter and limit width in bits.
RST_VAL, 0, value loaded into cnt on reset and on clr; must be <= 2**WIDTH-1.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
clr  input  1  synchronous clear: cnt<=RST_VAL, ovf<=0
load  input  1  synchronous load of load_val
load_val  input  WIDTH  value for load
inc  input  1  count-up request
dec  input  1  count-down request
sat_mode  input  1  1 = saturate at limits, 0 = wrap
max_val  input  WIDTH  upper limit; range is 0..max_val
cnt  output  WIDTH  current count (registered)
eq  output  1  combinational: cnt == max_val
zero  output  1  combinational: cnt == 0
tc  output  1  registered one-cycle pulse, high the cycle after a limit crossing or saturation attempt
ovf  output  1  sticky: set on any limit event, cleared by clr or rst

Behaviour:
Interface:
- One clock; reset is asynchronous and active-high.
- Ports are clk and rst.

Reset (rst=1, asynchronous):
- cnt=RST_VAL, tc=0, ovf=0.

Priority each cycle: clr > load > (inc xor dec).
- clr: cnt<=RST_VAL; ovf<=0; tc<=0.
- load: cnt<=min(load_val, max_val), i.e. clamped; tc and ovf unaffected by load.
- inc=1 and dec=1 together: no change, no event.
- Neither inc nor dec: hold; tc<=0.

Up (inc=1, dec=0):
- If cnt < max_val: cnt<=cnt+1.
- Else (cnt >= max_val, covering max_val lowered below cnt):
  - Limit event.
  - Wrap mode: cnt<=0.
  - Saturate mode: cnt<=max_val.

Down (dec=1, inc=0):
- If cnt > max_val: cnt<=max_val, with no event.
- Else if cnt > 0: cnt<=cnt-1.
- Else (cnt == 0):
  - Limit event.
  - Wrap mode: cnt<=max_val.
  - Saturate mode: hold at 0.

Limit event:
- tc<=1 for exactly one cycle.
- ovf<=1, which holds until clr or rst.
- Consecutive saturating requests give tc high on each following cycle.

Width and latency rules:
- No intermediate result exceeds WIDTH bits.
- Compare before add/subtract; never rely on natural modular overflow.
- max_val=0: every inc/dec is a limit event; cnt stays 0.
- max_val may change at any cycle; the new value is used immediately.
- Latency: cnt updates 1 cycle after request; tc 1 cycle after the causing request; eq/zero follow cnt combinationally.

Optional Feature:
COUNTER_PRESCALE_EN
- Defined:
  - Adds parameter PRESC_W (default 4).
  - Adds input presc_div [PRESC_W-1:0].
  - inc/dec are counted by an internal prescaler. The counter steps only on every (presc_div+1)-th cycle where exactly one of inc/dec is high.
  - Prescaler resets to 0 on rst, clr or load, and on a change of direction.
  - presc_div=0 is identical to the undefined build.
- Undefined: no prescaler logic or ports; every qualified request steps the counter.

Decomposition:
- Package counter_pkg:
  - step-direction enum (DIR_NONE, DIR_UP, DIR_DOWN)
  - limit-mode constants (MODE_WRAP=0, MODE_SAT=1)
- Sub-module counter_prescaler, instantiated only under COUNTER_PRESCALE_EN:
  - Inputs: clk, rst, restart, req, div.
  - Output: step pulse.

Test Plan:
1. WIDTH=4, max_val=5, wrap; pulse inc 7 cycles from 0 -> cnt 1,2,3,4,5,0,1; tc high one cycle after the 5->0 step; ovf=1.
2. sat_mode=1, max_val=9, cnt=9, inc held 3 cycles -> cnt stays 9; tc high 3 consecutive cycles; ovf=1; then clr -> cnt=0, ovf=0.
3. cnt=0, dec in wrap mode, max_val=12 -> cnt=12, tc pulse; dec again -> cnt=11, no tc.
4. load=1, load_val=15, max_val=10 -> cnt=10. Same cycle with clr=1 -> cnt=RST_VAL (clr wins). inc=dec=1 -> cnt unchanged, tc=0.
5. cnt=8, max_val lowered to 3: inc -> wrap to 0 with tc; separately from cnt=8, dec -> cnt=3 with no tc.
6. rst asserted mid-count with cnt=7 and tc=1 -> cnt=RST_VAL, tc=0, ovf=0 asynchronously, before the next clk edge. Under COUNTER_PRESCALE_EN with presc_div=2, 9 inc cycles -> cnt advances by 3.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types for updown_counter: step direction and limit-mode encodings.
package counter_pkg;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DOWN = 2'd2
  } dir_e;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // inc and dec together cancel out.
  function automatic dir_e decode_dir(input logic inc, input logic dec);
    if (inc && !dec) return DIR_UP;
    if (dec && !inc) return DIR_DOWN;
    return DIR_NONE;
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Request prescaler: emits one step per (div+1) qualified requests.
// Only instantiated when COUNTER_PRESCALE_EN is defined.
module counter_prescaler #(
  parameter int unsigned PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               restart,
  input  logic               req,
  input  logic [PRESC_W-1:0] div,
  output logic               step
);

  logic [PRESC_W-1:0] cnt_q, cnt_d, base;

  always_comb begin
    // A restart discards history but still lets this cycle's request count.
    base  = restart ? '0 : cnt_q;
    cnt_d = base;
    step  = 1'b0;
    if (req) begin
      if (base == div) begin
        step  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = base + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/updown_counter.sv
// Up/down counter with load, wrap/saturate limits, tc pulse and sticky ovf.
// Define COUNTER_PRESCALE_EN to add the presc_div request prescaler.
module updown_counter
  import counter_pkg::*;
#(
  parameter int unsigned      WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
`ifdef COUNTER_PRESCALE_EN
  ,
  parameter int unsigned      PRESC_W = 4
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             inc,
  input  logic             dec,
  input  logic             sat_mode,
  input  logic [WIDTH-1:0] max_val,
`ifdef COUNTER_PRESCALE_EN
  input  logic [PRESC_W-1:0] presc_div,
`endif
  output logic [WIDTH-1:0] cnt,
  output logic             eq,
  output logic             zero,
  output logic             tc,
  output logic             ovf
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  dir_e             dir;
  logic             step;

  assign dir = decode_dir(inc, dec);

`ifdef COUNTER_PRESCALE_EN
  dir_e last_dir_q;
  logic restart;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  last_dir_q <= DIR_NONE;
    else if (dir != DIR_NONE) last_dir_q <= dir;
  end

  assign restart = clr || load || ((dir != DIR_NONE) && (dir != last_dir_q));

  counter_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .req     ((dir != DIR_NONE) && !clr && !load),
    .div     (presc_div),
    .step    (step)
  );
`else
  assign step = (dir != DIR_NONE);
`endif

  // Limits are compared before stepping so no result ever leaves WIDTH bits.
  always_comb begin
    cnt_d = cnt_q;
    tc_d  = 1'b0;
    ovf_d = ovf_q;
    if (clr) begin
      cnt_d = RST_VAL;
      ovf_d = 1'b0;
    end else if (load) begin
      cnt_d = (load_val > max_val) ? max_val : load_val;
    end else if (step) begin
      unique case (dir)
        DIR_UP: begin
          if (cnt_q < max_val) begin
            cnt_d = cnt_q + 1'b1;
          end else begin
            tc_d  = 1'b1;
            ovf_d = 1'b1;
            cnt_d = (sat_mode == MODE_SAT) ? max_val : '0;
          end
        end
        DIR_DOWN: begin
          if (cnt_q > max_val) begin
            cnt_d = max_val;
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            tc_d  = 1'b1;
            ovf_d = 1'b1;
            cnt_d = (sat_mode == MODE_SAT) ? '0 : max_val;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= RST_VAL;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt  = cnt_q;
  assign tc   = tc_q;
  assign ovf  = ovf_q;
  assign eq   = (cnt_q == max_val);
  assign zero = (cnt_q == '0);

endmodule

// File: tb/tb_updown_counter.sv
// Directed bench for updown_counter (WIDTH=4, RST_VAL=0) with a cycle model.
// Covers the COUNTER_PRESCALE_EN build when that macro is defined.
module tb_updown_counter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, clr, load, inc, dec, sat_mode;
  logic [W-1:0] load_val, max_val, cnt;
  logic         eq, zero, tc, ovf;
`ifdef COUNTER_PRESCALE_EN
  logic [3:0]   presc_div;
`endif

  int checks   = 0;
  int failures = 0;

  // Model state: plain integers following the counting rules.
  int m_cnt, m_tc, m_ovf, m_p, m_last, d;
  bit fire;

  updown_counter #(
    .WIDTH   (W),
    .RST_VAL (4'd0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .inc      (inc),
    .dec      (dec),
    .sat_mode (sat_mode),
    .max_val  (max_val),
`ifdef COUNTER_PRESCALE_EN
    .presc_div(presc_div),
`endif
    .cnt      (cnt),
    .eq       (eq),
    .zero     (zero),
    .tc       (tc),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt = 0; m_tc = 0; m_ovf = 0; m_p = 0; m_last = 0;
    end else begin
      d    = (inc && !dec) ? 1 : ((dec && !inc) ? -1 : 0);
      m_tc = 0;
      if (clr) begin
        m_cnt = 0; m_ovf = 0; m_p = 0;
      end else if (load) begin
        m_cnt = (int'(load_val) > int'(max_val)) ? int'(max_val) : int'(load_val);
        m_p   = 0;
      end else if (d != 0) begin
        fire = 1'b1;
`ifdef COUNTER_PRESCALE_EN
        if (d != m_last) m_p = 0;
        m_last = d;
        if (m_p == int'(presc_div)) m_p = 0;
        else begin m_p++; fire = 1'b0; end
`endif
        if (fire) begin
          if (d == 1) begin
            if (m_cnt < int'(max_val)) m_cnt++;
            else begin m_tc = 1; m_ovf = 1; m_cnt = sat_mode ? int'(max_val) : 0; end
          end else begin
            if (m_cnt > int'(max_val)) m_cnt = int'(max_val);
            else if (m_cnt > 0) m_cnt--;
            else begin m_tc = 1; m_ovf = 1; m_cnt = sat_mode ? 0 : int'(max_val); end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("cmp_cnt", int'(cnt), m_cnt);
    chk("cmp_tc", int'(tc), m_tc);
    chk("cmp_ovf", int'(ovf), m_ovf);
    chk("cmp_eq", int'(eq), int'(m_cnt == int'(max_val)));
    chk("cmp_zero", int'(zero), int'(m_cnt == 0));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp1 [7] = '{1, 2, 3, 4, 5, 0, 1};

  initial begin
    rst = 1'b1; clr = 1'b0; load = 1'b0; inc = 1'b0; dec = 1'b0;
    sat_mode = 1'b0; load_val = 4'd0; max_val = 4'd5;
`ifdef COUNTER_PRESCALE_EN
    presc_div = 4'd0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("reset_cnt", int'(cnt), 0);
    chk("reset_tc", int'(tc), 0);
    chk("reset_ovf", int'(ovf), 0);
    chk("reset_zero", int'(zero), 1);
    rst = 1'b0;

    // Wrap through max_val=5.
    inc = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      chk("t1_cnt", int'(cnt), exp1[k]);
      chk("t1_tc", int'(tc), int'(k == 5));
    end
    chk("t1_ovf", int'(ovf), 1);
    inc = 1'b0;

    // Saturate at 9, then clear.
    sat_mode = 1'b1; max_val = 4'd9; load = 1'b1; load_val = 4'd9;
    tick();
    load = 1'b0; inc = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t2_cnt", int'(cnt), 9);
      chk("t2_tc", int'(tc), 1);
    end
    chk("t2_ovf", int'(ovf), 1);
    inc = 1'b0; clr = 1'b1;
    tick();
    chk("t2_clr_cnt", int'(cnt), 0);
    chk("t2_clr_ovf", int'(ovf), 0);
    chk("t2_clr_tc", int'(tc), 0);
    clr = 1'b0;

    // Down-wrap from 0.
    sat_mode = 1'b0; max_val = 4'd12; dec = 1'b1;
    tick();
    chk("t3_cnt", int'(cnt), 12);
    chk("t3_tc", int'(tc), 1);
    tick();
    chk("t3_cnt2", int'(cnt), 11);
    chk("t3_tc2", int'(tc), 0);
    dec = 1'b0;

    // Load clamp, clr priority, inc+dec cancel.
    load = 1'b1; load_val = 4'd15; max_val = 4'd10;
    tick();
    chk("t4_clamp", int'(cnt), 10);
    clr = 1'b1;
    tick();
    chk("t4_clr_wins", int'(cnt), 0);
    clr = 1'b0; load_val = 4'd5;
    tick();
    load = 1'b0; inc = 1'b1; dec = 1'b1;
    tick();
    chk("t4_both_cnt", int'(cnt), 5);
    chk("t4_both_tc", int'(tc), 0);
    inc = 1'b0; dec = 1'b0;

    // max_val lowered below cnt.
    max_val = 4'd15; load = 1'b1; load_val = 4'd8;
    tick();
    load = 1'b0; max_val = 4'd3; inc = 1'b1;
    tick();
    chk("t5_up_cnt", int'(cnt), 0);
    chk("t5_up_tc", int'(tc), 1);
    inc = 1'b0;
    tick();
    max_val = 4'd15; load = 1'b1;
    tick();
    load = 1'b0; max_val = 4'd3; dec = 1'b1;
    tick();
    chk("t5_dn_cnt", int'(cnt), 3);
    chk("t5_dn_tc", int'(tc), 0);
    dec = 1'b0;

    // max_val=0: every request is a limit event.
    clr = 1'b1;
    tick();
    clr = 1'b0; max_val = 4'd0; inc = 1'b1;
    tick();
    chk("max0_up_cnt", int'(cnt), 0);
    chk("max0_up_tc", int'(tc), 1);
    inc = 1'b0; dec = 1'b1; sat_mode = 1'b1;
    tick();
    chk("max0_dn_cnt", int'(cnt), 0);
    chk("max0_dn_tc", int'(tc), 1);
    dec = 1'b0;

    // Asynchronous reset mid-cycle.
    max_val = 4'd7; load = 1'b1; load_val = 4'd7;
    tick();
    load = 1'b0; inc = 1'b1;
    tick();
    chk("t6_pre_cnt", int'(cnt), 7);
    chk("t6_pre_tc", int'(tc), 1);
    inc = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_cnt", int'(cnt), 0);
    chk("t6_async_tc", int'(tc), 0);
    chk("t6_async_ovf", int'(ovf), 0);
    tick();
    rst = 1'b0;

    // Nine up-requests: prescaled by 3 when the prescaler is built in.
    sat_mode = 1'b0; max_val = 4'd15; inc = 1'b1;
`ifdef COUNTER_PRESCALE_EN
    presc_div = 4'd2;
`endif
    repeat (9) tick();
    inc = 1'b0;
`ifdef COUNTER_PRESCALE_EN
    chk("t6_presc_cnt", int'(cnt), 3);
`else
    chk("t6_steps_cnt", int'(cnt), 9);
`endif
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
